// File: rtl/ipv4_tx_framer.sv
// IPv4 TX framer: launches ip_encode, forwards its 20 header bytes, then streams payload toward the MAC.
// Optional IPV4_TX_MIN_PAD_EN pads short frames with zero bytes up to the 46-byte Ethernet minimum.
module ipv4_tx_framer #(
  parameter int MAX_PAYLOAD = 1480,
  parameter int HDR_BYTES   = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] sa,
  input  logic [31:0] da,
  input  logic [15:0] payload_len,
  output logic        busy,
  output logic        reject,
  output logic        ip_en,
  output logic [31:0] ip_sa,
  output logic [31:0] ip_da,
  output logic [15:0] ip_len,
  input  logic [7:0]  ip_dout,
  input  logic        ip_ovalid,
  input  logic [7:0]  pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        tx_last,
  output logic        tx_err,
  output logic        done
);
  localparam int MIN_PAY = 46 - HDR_BYTES;

  typedef enum logic [2:0] {IDLE, LAUNCH, HDR, PAY, FIN} state_t;
  state_t state, nxt;

  logic [4:0]  hcnt;
  logic [15:0] pcnt, len_q, tgt;
  logic [7:0]  q_data;
  logic        q_last, q_err;
  logic        hdr_end, hdr_ok, fill, in_pl, start_ok;

`ifdef IPV4_TX_MIN_PAD_EN
  assign tgt = (len_q < 16'(MIN_PAY)) ? 16'(MIN_PAY) : len_q;
`else
  assign tgt = len_q;
`endif

  // Payload bytes land in a one-byte stage (q_*) so the slot taken during the
  // byte-19 capture cycle can follow the header on tx_data without a gap.
  assign hdr_end  = (state == HDR) && (hcnt == 5'd19);
  assign hdr_ok   = hdr_end && ip_ovalid && (tgt != 16'd0);
  assign fill     = hdr_ok || ((state == PAY) && !q_last);
  assign in_pl    = pcnt < len_q;
  assign pl_ready = fill && in_pl;
  assign busy     = (state != IDLE);
  assign start_ok = start && (payload_len <= 16'(MAX_PAYLOAD));

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start_ok) nxt = LAUNCH;
      LAUNCH:  nxt = HDR;
      HDR:     if (hdr_end) nxt = hdr_ok ? PAY : FIN;
      PAY:     if (q_last) nxt = FIN;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hcnt     <= '0;
      pcnt     <= '0;
      len_q    <= '0;
      q_data   <= '0;
      q_last   <= 1'b0;
      q_err    <= 1'b0;
      ip_sa    <= '0;
      ip_da    <= '0;
      ip_len   <= '0;
      ip_en    <= 1'b0;
      reject   <= 1'b0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
      tx_err   <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= nxt;
      ip_en    <= (nxt == LAUNCH) || (nxt == HDR);
      reject   <= 1'b0;
      done     <= (state == FIN);
      tx_data  <= '0;
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
      tx_err   <= 1'b0;
      case (state)
        IDLE: begin
          hcnt   <= '0;
          pcnt   <= '0;
          q_last <= 1'b0;
          q_err  <= 1'b0;
          if (start_ok) begin
            ip_sa  <= sa;
            ip_da  <= da;
            len_q  <= payload_len;
            ip_len <= 16'(HDR_BYTES) + payload_len;
          end else if (start) begin
            reject <= 1'b1;
          end
        end
        HDR: begin
          tx_data  <= ip_dout;
          tx_valid <= 1'b1;
          hcnt     <= hcnt + 5'd1;
          if (hdr_end) begin
            tx_last <= !ip_ovalid || (tgt == 16'd0);
            tx_err  <= !ip_ovalid;
          end
        end
        PAY: begin
          tx_data  <= q_data;
          tx_valid <= 1'b1;
          tx_last  <= q_last;
          tx_err   <= q_err;
        end
        default: ;
      endcase
      if (fill) begin
        if (in_pl) begin
          // A missing payload byte becomes an aborting 0x00 slot.
          q_data <= pl_valid ? pl_data : 8'h00;
          q_err  <= !pl_valid;
          q_last <= !pl_valid || (pcnt == tgt - 16'd1);
          if (pl_valid) pcnt <= pcnt + 16'd1;
        end else begin
          q_data <= 8'h00;
          q_err  <= 1'b0;
          q_last <= (pcnt == tgt - 16'd1);
          pcnt   <= pcnt + 16'd1;
        end
      end
    end
  end
endmodule
